// File: rtl/alu_sequencer.sv
// Multi-cycle front end for the combinational ALU: latches an accumulator-class
// request, runs a binary pass plus an optional BCD correction pass, and returns a one-cycle result pulse.
module alu_sequencer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_c,
  input  logic       req_d,
  output logic [2:0] alu_control,
  output logic [7:0] alu_AI,
  output logic [7:0] alu_BI,
  output logic       alu_carry_in,
  input  logic [7:0] alu_Y,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  output logic       res_valid,
  output logic [7:0] res_y,
  output logic       res_n,
  output logic       res_v,
  output logic       res_z,
  output logic       res_c,
  output logic [3:0] res_mask,
  output logic       res_wb,
  output logic [1:0] dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // the requester holds req_valid and the operands stable until that edge.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DEC = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [2:0] OP_ADC = 3'b000;
  localparam logic [2:0] OP_SBC = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORA = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;
  localparam logic [2:0] OP_ASL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SR  = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q;
  logic       c_q, d_q;
  logic [7:0] r_q;
  logic       cbin_q, v_q, h_q;

  logic       is_bcd;
  logic [4:0] h_sum;
  logic [7:0] dec_adj;
  logic       dec_c;
  logic       dec_hi_hit;
  logic [7:0] fin_y;
  logic       fin_v, fin_c, fin_wb;
  logic [3:0] fin_mask;
  logic       load_res;

  assign req_ready = (state == S_IDLE);
  assign res_valid = (state == S_DONE);
  assign dbg_state = state;
  assign is_bcd    = d_q && ((op_q == OP_ADC) || (op_q == OP_SBC));

  // Half-carry of the binary pass, taken from the operands actually driven in EXEC.
  assign h_sum = {1'b0, alu_AI[3:0]} + {1'b0, alu_BI[3:0]} + {4'b0000, alu_carry_in};

  always_comb begin
    state_nxt    = state;
    alu_control  = ALU_ADD;
    alu_AI       = 8'h00;
    alu_BI       = 8'h00;
    alu_carry_in = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_AI = a_q;
        case (op_q)
          OP_ADC: begin alu_BI = b_q;  alu_carry_in = c_q;  end
          OP_SBC: begin alu_BI = ~b_q; alu_carry_in = c_q;  end
          OP_CMP: begin alu_BI = ~b_q; alu_carry_in = 1'b1; end
          OP_AND: begin alu_control = ALU_AND; alu_BI = b_q; end
          OP_ORA: begin alu_control = ALU_OR;  alu_BI = b_q; end
          OP_EOR: begin alu_control = ALU_XOR; alu_BI = b_q; end
          OP_LSR: alu_control = ALU_SR;
          OP_ASL: alu_BI = a_q;
          default: ;
        endcase
        state_nxt = is_bcd ? S_DEC : S_DONE;
      end
      S_DEC: begin
        alu_AI    = r_q;
        alu_BI    = dec_adj;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // BCD correction constant; the SBC form relies on 8-bit wraparound of the sum.
  always_comb begin
    dec_hi_hit = cbin_q || (r_q > 8'h99);
    dec_adj    = 8'h00;
    dec_c      = cbin_q;
    if (op_q == OP_SBC) begin
      dec_adj = (h_q ? 8'h00 : 8'hFA) + (cbin_q ? 8'h00 : 8'hA0);
    end else begin
      dec_adj = ((h_q || (r_q[3:0] > 4'd9)) ? 8'h06 : 8'h00) + (dec_hi_hit ? 8'h60 : 8'h00);
      dec_c   = dec_hi_hit;
    end
  end

  always_comb begin
    fin_y    = alu_Y;
    fin_v    = 1'b0;
    fin_c    = 1'b0;
    fin_mask = 4'b1011;
    fin_wb   = 1'b1;
    if (state == S_DEC) begin
      fin_v    = v_q;
      fin_c    = dec_c;
      fin_mask = 4'b1111;
    end else begin
      case (op_q)
        OP_ADC, OP_SBC: begin
          fin_v    = alu_overflow;
          fin_c    = alu_carry_out;
          fin_mask = 4'b1111;
        end
        OP_CMP: begin
          fin_c  = alu_carry_out;
          fin_wb = 1'b0;
        end
        OP_AND, OP_ORA, OP_EOR: fin_mask = 4'b1010;
        default: fin_c = alu_carry_out;
      endcase
    end
  end

  assign load_res = ((state == S_EXEC) && !is_bcd) || (state == S_DEC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      op_q     <= 3'b000;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      c_q      <= 1'b0;
      d_q      <= 1'b0;
      r_q      <= 8'h00;
      cbin_q   <= 1'b0;
      v_q      <= 1'b0;
      h_q      <= 1'b0;
      res_y    <= 8'h00;
      res_n    <= 1'b0;
      res_v    <= 1'b0;
      res_z    <= 1'b0;
      res_c    <= 1'b0;
      res_mask <= 4'b0000;
      res_wb   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && req_valid) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
        c_q  <= req_c;
        d_q  <= req_d;
      end
      if (state == S_EXEC) begin
        r_q    <= alu_Y;
        cbin_q <= alu_carry_out;
        v_q    <= alu_overflow;
        h_q    <= h_sum[4];
      end
      if (load_res) begin
        res_y    <= fin_y;
        res_n    <= fin_y[7];
        res_v    <= fin_v;
        res_z    <= (fin_y == 8'h00);
        res_c    <= fin_c;
        res_mask <= fin_mask;
        res_wb   <= fin_wb;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, decimal-arithmetic reference model,
// expected-result queue, and scenario tasks run in sequence.
module tb_alu_sequencer;

  logic       clk;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a, req_b;
  logic       req_c, req_d;
  logic [2:0] alu_control;
  logic [7:0] alu_AI, alu_BI;
  logic       alu_carry_in;
  logic [7:0] alu_Y;
  logic       alu_carry_out, alu_overflow;
  logic       res_valid;
  logic [7:0] res_y;
  logic       res_n, res_v, res_z, res_c;
  logic [3:0] res_mask;
  logic       res_wb;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int hs_count = 0;
  logic [16:0] exp_q[$];

  alu_sequencer dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI), .alu_carry_in(alu_carry_in),
    .alu_Y(alu_Y), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_y(res_y), .res_n(res_n), .res_v(res_v), .res_z(res_z),
    .res_c(res_c), .res_mask(res_mask), .res_wb(res_wb), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (resetn && req_valid && req_ready) hs_count <= hs_count + 1;
  end

  // Behavioural combinational ALU
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum       = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'd0, alu_carry_in};
    alu_Y         = 8'h00;
    alu_carry_out = 1'b0;
    alu_overflow  = 1'b0;
    case (alu_control)
      3'b000: begin
        alu_Y         = alu_sum[7:0];
        alu_carry_out = alu_sum[8];
        alu_overflow  = (alu_AI[7] == alu_BI[7]) && (alu_sum[7] != alu_AI[7]);
      end
      3'b001: begin
        alu_Y         = {alu_carry_in, alu_AI[7:1]};
        alu_carry_out = alu_AI[0];
      end
      3'b010: alu_Y = alu_AI & alu_BI;
      3'b011: alu_Y = alu_AI | alu_BI;
      3'b100: alu_Y = alu_AI ^ alu_BI;
      default: ;
    endcase
  end

  // Reference model: packed {y, n, v, z, c, mask[3:0], wb}
  function automatic logic [16:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic d);
    logic [7:0] y, bb;
    logic [8:0] s9;
    logic       co, v, wb;
    logic [3:0] mask;
    int         da, db, ds;
    y = 8'h00; bb = 8'h00; s9 = 9'd0; co = 1'b0; v = 1'b0; wb = 1'b1; mask = 4'b1011;
    da = int'(a[7:4]) * 10 + int'(a[3:0]);
    db = int'(b[7:4]) * 10 + int'(b[3:0]);
    ds = 0;
    case (op)
      3'b000, 3'b001: begin
        bb   = (op == 3'b000) ? b : ~b;
        s9   = {1'b0, a} + {1'b0, bb} + {8'd0, c};
        y    = s9[7:0];
        co   = s9[8];
        v    = (a[7] == bb[7]) && (y[7] != a[7]);
        mask = 4'b1111;
        if (d) begin
          if (op == 3'b000) begin
            ds = da + db + int'(c);
            co = (ds > 99);
            ds = ds % 100;
          end else begin
            ds = da - db - (c ? 0 : 1);
            co = (ds >= 0);
            if (ds < 0) ds = ds + 100;
          end
          y[7:4] = 4'(ds / 10);
          y[3:0] = 4'(ds % 10);
        end
      end
      3'b111: begin
        bb = ~b;
        s9 = {1'b0, a} + {1'b0, bb} + 9'd1;
        y  = s9[7:0];
        co = s9[8];
        wb = 1'b0;
      end
      3'b010: begin y = a & b; mask = 4'b1010; end
      3'b011: begin y = a | b; mask = 4'b1010; end
      3'b100: begin y = a ^ b; mask = 4'b1010; end
      3'b101: begin y = {1'b0, a[7:1]}; co = a[0]; end
      default: begin y = {a[6:0], 1'b0}; co = a[7]; end
    endcase
    return {y, y[7], v, (y == 8'h00), co, mask, wb};
  endfunction

  function automatic logic [7:0] rand_bcd();
    logic [7:0] r;
    r[7:4] = 4'($urandom_range(0, 9));
    r[3:0] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Driver: offer a request at the negative edge until accepted; push the expectation on acceptance.
  task automatic send_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic d, input bit hold);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_c = c; req_d = d;
      req_valid = 1'b1;
      if (req_ready) begin
        exp_q.push_back(model(op, a, b, c, d));
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_req accept: got req_ready low for 20 cycles, required an accept");
      req_valid = 1'b0;
    end
  endtask

  // Monitor: wait (bounded) for res_valid; lat is the cycle index k+lat relative to the accept edge k.
  task automatic wait_res(output logic [16:0] got, output int lat);
    got = 17'h0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid) begin
        got = {res_y, res_n, res_v, res_z, res_c, res_mask, res_wb};
        lat = i + 1;
        break;
      end
    end
    n_cmp++;
    if (lat == 0) begin
      n_err++;
      $display("FAIL wait_res timeout: got no res_valid in 10 cycles, required a result pulse");
    end
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    req_valid = 1'b0; req_op = 3'b000; req_a = 8'h00; req_b = 8'h00; req_c = 1'b0; req_d = 1'b0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {res_valid, res_y, res_n, res_v, res_z, res_c, res_mask, res_wb,
            alu_control, alu_AI, alu_BI, alu_carry_in};
    n_cmp++;
    if (outs !== 38'd0) begin
      n_err++;
      $display("FAIL reset outputs: got %h required 0", outs);
    end
    n_cmp++;
    if (req_ready !== 1'b1 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset ready/state: got %b/%0d required 1/0", req_ready, dbg_state);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_binary_arith();
    logic [16:0] got, exp;
    int lat;
    send_req(3'b000, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
    wait_res(got, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || got !== {8'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1}) begin
      n_err++;
      $display("FAIL adc_bin result: got %h required %h", got, exp);
    end
    n_cmp++;
    if (lat != 2) begin
      n_err++;
      $display("FAIL adc_bin latency: got k+%0d required k+2", lat);
    end
    send_req(3'b001, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    wait_res(got, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || got[16:5] !== {8'hFF, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sbc_bin result: got %h required %h", got, exp);
    end
  endtask

  task automatic test_decimal();
    logic [16:0] got, exp;
    int lat;
    send_req(3'b000, 8'h58, 8'h46, 1'b1, 1'b1, 1'b0);
    wait_res(got, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || got[16:9] !== 8'h05 || got[5] !== 1'b1 || got[6] !== 1'b0) begin
      n_err++;
      $display("FAIL adc_dec result: got %h required %h", got, exp);
    end
    n_cmp++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL adc_dec latency: got k+%0d required k+3", lat);
    end
    send_req(3'b001, 8'h12, 8'h21, 1'b1, 1'b1, 1'b0);
    wait_res(got, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || got[16:9] !== 8'h91 || got[5] !== 1'b0 || got[8] !== 1'b1) begin
      n_err++;
      $display("FAIL sbc_dec result: got %h required %h", got, exp);
    end
  endtask

  task automatic test_cmp_shift_logic();
    logic [2:0] ops [6] = '{3'b111, 3'b101, 3'b110, 3'b010, 3'b011, 3'b100};
    logic [7:0] as  [6] = '{8'h40, 8'h01, 8'h81, 8'hF0, 8'h0C, 8'h5A};
    logic [7:0] bs  [6] = '{8'h40, 8'hFF, 8'h33, 8'h3C, 8'h80, 8'h5A};
    logic [16:0] lit[6] = '{{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0},
                            {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1},
                            {8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1},
                            {8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1},
                            {8'h8C, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1},
                            {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 1'b1}};
    logic [16:0] got, exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      send_req(ops[i], as[i], bs[i], 1'b1, 1'b1, 1'b0);
      wait_res(got, lat);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || got !== lit[i] || lat != 2) begin
        n_err++;
        $display("FAIL op%0d table: got %h lat %0d required %h lat 2", ops[i], got, lat, lit[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] got, exp;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic        c, d;
    int          lat, exp_lat;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      c  = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      if (d && (op == 3'b000 || op == 3'b001)) begin
        a = rand_bcd();
        b = rand_bcd();
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      exp_lat = (d && (op == 3'b000 || op == 3'b001)) ? 3 : 2;
      send_req(op, a, b, c, d, 1'b0);
      wait_res(got, lat);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || lat != exp_lat) begin
        n_err++;
        $display("FAIL random op=%0d a=%h b=%h c=%b d=%b: got %h lat %0d required %h lat %0d",
                 op, a, b, c, d, got, lat, exp, exp_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] got1, got2, exp;
    int lat, gap, hs_before;
    bit seen1;
    hs_before = hs_count;
    seen1 = 1'b0;
    gap = 0;
    got1 = 17'h0;
    send_req(3'b000, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    req_op = 3'b001; req_a = 8'h45; req_b = 8'h17; req_c = 1'b1; req_d = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (res_valid) begin
        got1  = {res_y, res_n, res_v, res_z, res_c, res_mask, res_wb};
        seen1 = 1'b1;
      end
      if (req_ready) begin
        exp_q.push_back(model(3'b001, 8'h45, 8'h17, 1'b1, 1'b1));
        @(posedge clk);
        #1 req_valid = 1'b0;
        gap = i;
        break;
      end
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (!seen1 || got1 !== exp) begin
      n_err++;
      $display("FAIL b2b first: got %h (seen %b) required %h", got1, seen1, exp);
    end
    n_cmp++;
    if (gap != 3) begin
      n_err++;
      $display("FAIL b2b spacing: got %0d cycles required 3", gap);
    end
    wait_res(got2, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got2 !== exp || got2[16:9] !== 8'h28 || lat != 3) begin
      n_err++;
      $display("FAIL b2b second: got %h lat %0d required %h lat 3", got2, lat, exp);
    end
    n_cmp++;
    if (hs_count - hs_before != 2) begin
      n_err++;
      $display("FAIL b2b accepts: got %0d required 2", hs_count - hs_before);
    end
  endtask

  task automatic test_reset_mid_dec();
    logic [37:0] outs;
    logic [16:0] got, exp;
    int lat, rv_seen;
    rv_seen = 0;
    send_req(3'b000, 8'h58, 8'h46, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    n_cmp++;
    if (dbg_state !== 2'd2) begin
      n_err++;
      $display("FAIL mid_dec state: got %0d required 2", dbg_state);
    end
    resetn = 1'b0;
    #1;
    outs = {res_valid, res_y, res_n, res_v, res_z, res_c, res_mask, res_wb,
            alu_control, alu_AI, alu_BI, alu_carry_in};
    n_cmp++;
    if (outs !== 38'd0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_dec reset outputs: got %h ready %b required 0 ready 1", outs, req_ready);
    end
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    resetn = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_dec ready after release: got %b required 1", req_ready);
    end
    repeat (4) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    n_cmp++;
    if (rv_seen != 0) begin
      n_err++;
      $display("FAIL mid_dec res_valid: got %0d pulses required 0", rv_seen);
    end
    send_req(3'b000, 8'h19, 8'h28, 1'b0, 1'b1, 1'b0);
    wait_res(got, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || got[16:9] !== 8'h47 || lat != 3) begin
      n_err++;
      $display("FAIL after_reset adc: got %h lat %0d required %h lat 3", got, lat, exp);
    end
  endtask

  initial begin
    test_reset();
    test_binary_arith();
    test_decimal();
    test_cmp_shift_logic();
    test_random();
    test_back_to_back();
    test_reset_mid_dec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
